multicycle_control_unit: RTL

- Multi-cycle FSM control unit for the RV32I datapath; replaces the single-cycle combinational decoder.
- Sequences FETCH/DECODE/EXEC/MEM/WB per instruction and drives registered datapath controls.
- Handshakes with a shared instruction/data memory port; stalls on memory wait states.
- Covers the full RV32I branch set, JAL/JALR, LUI/AUIPC and illegal-opcode trapping.

---
 rtl/ctrl_pkg.sv | 117 +++++++++++
 rtl/branch_eval.sv | 28 ++
 rtl/multicycle_control_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle controller:
// opcodes, FSM states, mux selects and the opcode decoder.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] PCSRC_PC4 = 2'd0;
  localparam logic [1:0] PCSRC_IMM = 2'd1;
  localparam logic [1:0] PCSRC_ALU = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  typedef enum logic [3:0] {
    C_NOP, C_R, C_I, C_LOAD, C_STORE,
    C_BRANCH, C_JAL, C_JALR, C_LUI,
    C_AUIPC, C_ILL
  } cls_e;

  typedef struct packed {
    cls_e       cls;
    logic [2:0] imm;
    logic       src_a;
    logic       src_b;
    logic [3:0] alu_op;
  } dec_t;

  localparam dec_t DEC_NOP = '{
    cls: C_NOP, imm: IMM_I, src_a: 1'b0,
    src_b: 1'b0, alu_op: 4'b0000
  };

  function automatic dec_t decode(
    input logic [6:0] opc,
    input logic [2:0] f3,
    input logic       b30
  );
    dec_t d;
    d = '{
      cls: C_ILL, imm: IMM_I, src_a: 1'b0,
      src_b: 1'b0, alu_op: 4'b0000
    };
    unique case (1'b1)
      opc == OP_R: begin
        d.cls    = C_R;
        d.alu_op = {b30, f3};
      end
      opc == OP_I: begin
        d.cls    = C_I;
        d.src_b  = 1'b1;
        d.alu_op = {(f3 == 3'b101) & b30, f3};
      end
      opc == OP_LOAD: begin
        d.cls   = C_LOAD;
        d.src_b = 1'b1;
      end
      opc == OP_STORE: begin
        d.cls   = C_STORE;
        d.imm   = IMM_S;
        d.src_b = 1'b1;
      end
      opc == OP_BRANCH: begin
        d.cls    = C_BRANCH;
        d.imm    = IMM_B;
        d.alu_op = 4'b1000;
      end
      opc == OP_JAL: begin
        d.cls   = C_JAL;
        d.imm   = IMM_J;
        d.src_a = 1'b1;
        d.src_b = 1'b1;
      end
      opc == OP_JALR: begin
        d.cls   = C_JALR;
        d.src_b = 1'b1;
      end
      opc == OP_LUI: begin
        d.cls = C_LUI;
        d.imm = IMM_U;
      end
      opc == OP_AUIPC: begin
        d.cls   = C_AUIPC;
        d.imm   = IMM_U;
        d.src_a = 1'b1;
        d.src_b = 1'b1;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/branch_eval.sv
// RV32I branch condition from funct3 and ALU flags {N,Z,C,V}.
// valid_o is low for the two unassigned funct3 codes.
module branch_eval (
  input  logic [2:0] funct3_i,
  input  logic [3:0] status_i,
  output logic       taken_o,
  output logic       valid_o
);

  logic n, z, c, v;
  assign {n, z, c, v} = status_i;

  always_comb begin
    taken_o = 1'b0;
    valid_o = 1'b1;
    unique case (funct3_i)
      3'b000: taken_o = z;
      3'b001: taken_o = ~z;
      3'b100: taken_o = n ^ v;
      3'b101: taken_o = ~(n ^ v);
      3'b110: taken_o = ~c;
      3'b111: taken_o = c;
      3'b010,
      3'b011: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB/TRAP.
// Outputs are registered with the values of the state being entered.
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int         XLEN       = 32,
  parameter int         ALUOP_W    = 4,
  parameter logic [6:0] NOP_OPCODE = 7'b0000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [XLEN-1:0]    instr,
  input  logic [3:0]         status,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               ir_load,
  output logic               pc_write,
  output logic [1:0]         pcsrc,
  output logic               alusrc_a,
  output logic               alusrc,
  output logic [2:0]         imm_select,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               reg_we,
  output logic [1:0]         wb_sel,
  output logic               illegal,
  output logic [2:0]         state_o
);

  state_e               state_q;
  cls_e                 cls_q;
  logic                 mem_req_q, mem_we_q;
  logic                 ir_load_q, pc_write_q;
  logic [1:0]           pcsrc_q, wb_sel_q;
  logic                 alusrc_a_q, alusrc_q;
  logic [2:0]           imm_sel_q;
  logic [ALUOP_W-1:0]   alu_op_q;
  logic                 reg_we_q, illegal_q;

  dec_t dec;
  logic br_taken, br_valid;
  logic unused_instr;

  assign dec = (instr[6:0] == NOP_OPCODE) ? DEC_NOP
             : decode(instr[6:0], instr[14:12], instr[30]);

  assign unused_instr = ^{instr[XLEN-1:31], instr[29:15], instr[11:7]};

  branch_eval u_br (
    .funct3_i (instr[14:12]),
    .status_i (status),
    .taken_o  (br_taken),
    .valid_o  (br_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_FETCH;
      cls_q      <= C_NOP;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      ir_load_q  <= 1'b0;
      pc_write_q <= 1'b0;
      pcsrc_q    <= PCSRC_PC4;
      alusrc_a_q <= 1'b0;
      alusrc_q   <= 1'b0;
      imm_sel_q  <= IMM_I;
      alu_op_q   <= '0;
      reg_we_q   <= 1'b0;
      wb_sel_q   <= WB_ALU;
      illegal_q  <= 1'b0;
    end else begin
      ir_load_q  <= 1'b0;
      pc_write_q <= 1'b0;
      pcsrc_q    <= PCSRC_PC4;
      reg_we_q   <= 1'b0;
      unique case (state_q)
        S_FETCH: begin
          mem_we_q <= 1'b0;
          // first FETCH after reset only raises the request
          if (mem_req_q && mem_ready) begin
            mem_req_q <= 1'b0;
            ir_load_q <= 1'b1;
            state_q   <= S_DECODE;
          end else begin
            mem_req_q <= 1'b1;
          end
        end
        S_DECODE: begin
          cls_q      <= dec.cls;
          imm_sel_q  <= dec.imm;
          alusrc_a_q <= dec.src_a;
          alusrc_q   <= dec.src_b;
          alu_op_q   <= ALUOP_W'(dec.alu_op);
          state_q    <= S_EXEC;
          unique case (dec.cls)
            C_ILL: begin
              state_q   <= S_TRAP;
              illegal_q <= 1'b1;
            end
            C_NOP: pc_write_q <= 1'b1;
            C_BRANCH: begin
              if (br_valid) begin
                pc_write_q <= 1'b1;
                pcsrc_q    <= br_taken ? PCSRC_IMM
                                       : PCSRC_PC4;
              end else begin
                state_q   <= S_TRAP;
                illegal_q <= 1'b1;
              end
            end
            C_JAL: begin
              pc_write_q <= 1'b1;
              pcsrc_q    <= PCSRC_IMM;
            end
            C_JALR: begin
              pc_write_q <= 1'b1;
              pcsrc_q    <= PCSRC_ALU;
            end
            default: ;
          endcase
        end
        S_EXEC: begin
          unique case (cls_q)
            C_LOAD, C_STORE: begin
              state_q    <= S_MEM;
              mem_req_q  <= 1'b1;
              mem_we_q   <= (cls_q == C_STORE);
              // store address comes from the ALU, so PC can advance now
              pc_write_q <= (cls_q == C_STORE);
            end
            C_JAL, C_JALR: begin
              state_q  <= S_WB;
              reg_we_q <= 1'b1;
              wb_sel_q <= WB_PC4;
            end
            C_LUI: begin
              state_q    <= S_WB;
              reg_we_q   <= 1'b1;
              pc_write_q <= 1'b1;
              wb_sel_q   <= WB_IMM;
            end
            C_R, C_I, C_AUIPC: begin
              state_q    <= S_WB;
              reg_we_q   <= 1'b1;
              pc_write_q <= 1'b1;
              wb_sel_q   <= WB_ALU;
            end
            default: begin
              state_q   <= S_FETCH;
              mem_req_q <= 1'b1;
            end
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            mem_we_q <= 1'b0;
            if (cls_q == C_STORE) begin
              state_q <= S_FETCH;
            end else begin
              state_q    <= S_WB;
              mem_req_q  <= 1'b0;
              reg_we_q   <= 1'b1;
              pc_write_q <= 1'b1;
              wb_sel_q   <= WB_MEM;
            end
          end
        end
        S_WB: begin
          state_q   <= S_FETCH;
          mem_req_q <= 1'b1;
        end
        S_TRAP: begin
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
          illegal_q <= 1'b1;
        end
        default: begin
          state_q   <= S_TRAP;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
          illegal_q <= 1'b1;
        end
      endcase
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign ir_load    = ir_load_q;
  assign pc_write   = pc_write_q;
  assign pcsrc      = pcsrc_q;
  assign alusrc_a   = alusrc_a_q;
  assign alusrc     = alusrc_q;
  assign imm_select = imm_sel_q;
  assign alu_op     = alu_op_q;
  assign reg_we     = reg_we_q;
  assign wb_sel     = wb_sel_q;
  assign illegal    = illegal_q;
  assign state_o    = state_q;

endmodule
